reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 99 +++++++++
 tb/tb_reg_file_sb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file with a per-register pending (scoreboard) bit, a dedicated R0 write port and synchronous reads.
// Optional same-edge write-to-read bypass is enabled by defining REGF_BYPASS_EN.
module reg_file_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLOCK,
  input  logic              in_rst,
  input  logic [ADDR_W-1:0] in_op1_addr,
  input  logic [ADDR_W-1:0] in_op2_addr,
  input  logic [1:0]        in_cntrl_regwrite,
  input  logic [ADDR_W-1:0] in_wr_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_r0,
  input  logic              in_issue_valid,
  input  logic [ADDR_W-1:0] in_issue_addr,
  input  logic              in_issue_r0,
  output logic [DATA_W-1:0] out_op1_data,
  output logic [DATA_W-1:0] out_op2_data,
  output logic              out_op1_busy,
  output logic              out_op2_busy,
  output logic              out_stall,
  output logic [ADDR_W:0]   out_pending_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs     [DEPTH];
  logic [DATA_W-1:0] reg_next [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_next;
  logic [DEPTH-1:0]  written;
  logic [DEPTH-1:0]  issued;
  logic [ADDR_W:0]   cnt_next;

  // R0 port is applied after the general port so it wins a collision on register 0.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      reg_next[i] = regs[i];
      written[i]  = 1'b0;
      issued[i]   = 1'b0;
      if (in_cntrl_regwrite[0] && in_wr_addr == ADDR_W'(i)) begin
        reg_next[i] = in_data;
        written[i]  = 1'b1;
      end
      if (in_cntrl_regwrite[1] && i == 0) begin
        reg_next[i] = in_r0;
        written[i]  = 1'b1;
      end
      if (in_issue_valid && in_issue_addr == ADDR_W'(i)) issued[i] = 1'b1;
      if (in_issue_r0 && i == 0) issued[i] = 1'b1;
    end
    // A new issue wins over a retiring write to the same register.
    pending_next = issued | (pending & ~written);
    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_next = cnt_next + {{ADDR_W{1'b0}}, pending_next[i]};
    end
  end

`ifdef REGF_BYPASS_EN
  logic [DEPTH-1:0] clearing;

  always_comb begin
    clearing     = written & ~issued;
    out_op1_busy = pending[in_op1_addr] & ~clearing[in_op1_addr];
    out_op2_busy = pending[in_op2_addr] & ~clearing[in_op2_addr];
  end
`else
  always_comb begin
    out_op1_busy = pending[in_op1_addr];
    out_op2_busy = pending[in_op2_addr];
  end
`endif

  assign out_stall = (out_op1_busy | out_op2_busy) & ~in_rst;

  always_ff @(posedge CLOCK or posedge in_rst) begin
    if (in_rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending         <= '0;
      out_pending_cnt <= '0;
      out_op1_data    <= '0;
      out_op2_data    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= reg_next[i];
      pending         <= pending_next;
      out_pending_cnt <= cnt_next;
`ifdef REGF_BYPASS_EN
      out_op1_data    <= reg_next[in_op1_addr];
      out_op2_data    <= reg_next[in_op2_addr];
`else
      out_op1_data    <= regs[in_op1_addr];
      out_op2_data    <= regs[in_op2_addr];
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios followed by randomized traffic
// compared against an array-based model of the register file and its pending set.
module tb_reg_file_sb;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              CLOCK;
  logic              in_rst;
  logic [ADDR_W-1:0] in_op1_addr, in_op2_addr;
  logic [1:0]        in_cntrl_regwrite;
  logic [ADDR_W-1:0] in_wr_addr;
  logic [DATA_W-1:0] in_data, in_r0;
  logic              in_issue_valid;
  logic [ADDR_W-1:0] in_issue_addr;
  logic              in_issue_r0;
  logic [DATA_W-1:0] out_op1_data, out_op2_data;
  logic              out_op1_busy, out_op2_busy, out_stall;
  logic [ADDR_W:0]   out_pending_cnt;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] m_reg [DEPTH];
  logic [DEPTH-1:0]  m_pend;
  logic [DATA_W-1:0] exp_q[$];

  reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLOCK(CLOCK), .in_rst(in_rst),
    .in_op1_addr(in_op1_addr), .in_op2_addr(in_op2_addr),
    .in_cntrl_regwrite(in_cntrl_regwrite), .in_wr_addr(in_wr_addr),
    .in_data(in_data), .in_r0(in_r0),
    .in_issue_valid(in_issue_valid), .in_issue_addr(in_issue_addr), .in_issue_r0(in_issue_r0),
    .out_op1_data(out_op1_data), .out_op2_data(out_op2_data),
    .out_op1_busy(out_op1_busy), .out_op2_busy(out_op2_busy),
    .out_stall(out_stall), .out_pending_cnt(out_pending_cnt)
  );

  // Clock / reset
  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_reg[i] = '0;
    m_pend = '0;
    exp_q.delete();
  endtask

  // Driver
  task automatic drive(input logic [1:0] wr, input logic [3:0] wa, input logic [15:0] d,
                       input logic [15:0] r0, input logic [3:0] a1, input logic [3:0] a2,
                       input logic iv, input logic [3:0] ia, input logic ir);
    in_cntrl_regwrite = wr; in_wr_addr = wa; in_data = d; in_r0 = r0;
    in_op1_addr = a1; in_op2_addr = a2;
    in_issue_valid = iv; in_issue_addr = ia; in_issue_r0 = ir;
  endtask

  function automatic logic is_written(input int r);
    return (in_cntrl_regwrite[0] && int'(in_wr_addr) == r) || (in_cntrl_regwrite[1] && r == 0);
  endfunction

  function automatic logic is_issued(input int r);
    return (in_issue_valid && int'(in_issue_addr) == r) || (in_issue_r0 && r == 0);
  endfunction

  function automatic logic exp_busy(input int r);
`ifdef REGF_BYPASS_EN
    return m_pend[r] && !(is_written(r) && !is_issued(r));
`else
    return m_pend[r];
`endif
  endfunction

  // One clock: check combinational busy/stall, predict, clock, compare registered outputs.
  task automatic tick();
    logic [DATA_W-1:0] new_reg [DEPTH];
    logic [DEPTH-1:0]  new_pend;
    logic              b1, b2;
    #1;
    b1 = exp_busy(int'(in_op1_addr));
    b2 = exp_busy(int'(in_op2_addr));
    check("op1_busy", 32'(out_op1_busy), 32'(b1));
    check("op2_busy", 32'(out_op2_busy), 32'(b2));
    check("stall", 32'(out_stall), 32'(b1 | b2));
    for (int i = 0; i < DEPTH; i++) new_reg[i] = m_reg[i];
    if (in_cntrl_regwrite[0]) new_reg[in_wr_addr] = in_data;
    if (in_cntrl_regwrite[1]) new_reg[0] = in_r0;
`ifdef REGF_BYPASS_EN
    exp_q.push_back(new_reg[in_op1_addr]);
    exp_q.push_back(new_reg[in_op2_addr]);
`else
    exp_q.push_back(m_reg[in_op1_addr]);
    exp_q.push_back(m_reg[in_op2_addr]);
`endif
    new_pend = m_pend;
    for (int i = 0; i < DEPTH; i++) begin
      if (is_written(i)) new_pend[i] = 1'b0;
      if (is_issued(i))  new_pend[i] = 1'b1;
    end
    @(posedge CLOCK);
    #1;
    for (int i = 0; i < DEPTH; i++) m_reg[i] = new_reg[i];
    m_pend = new_pend;
    check("op1_data", 32'(out_op1_data), 32'(exp_q.pop_front()));
    check("op2_data", 32'(out_op2_data), 32'(exp_q.pop_front()));
    check("pending_cnt", 32'(out_pending_cnt), 32'($countones(m_pend)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_op1"}, 32'(out_op1_data), 32'h0);
    check({tag, "_op2"}, 32'(out_op2_data), 32'h0);
    check({tag, "_cnt"}, 32'(out_pending_cnt), 32'h0);
    check({tag, "_stall"}, 32'(out_stall), 32'h0);
  endtask

  initial begin
    logic [1:0] wr;
    in_rst = 1'b1;
    drive(2'b00, 4'd0, 16'h0, 16'h0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    model_reset();
    #3;
    check_all_zero("reset_init");
    #9;
    in_rst = 1'b0;

    // General write then read back
    drive(2'b01, 4'd4, 16'h00CC, 16'h0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0); tick();
    drive(2'b00, 4'd0, 16'h0, 16'h0, 4'd4, 4'd0, 1'b0, 4'd0, 1'b0); tick();
    check("wr_rd_r4", 32'(out_op1_data), 32'h00CC);

    // Dual-write collisions
    drive(2'b11, 4'd0, 16'h000F, 16'hF000, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0); tick();
    drive(2'b11, 4'd2, 16'h000F, 16'hF000, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0); tick();
    drive(2'b00, 4'd0, 16'h0, 16'h0, 4'd0, 4'd2, 1'b0, 4'd0, 1'b0); tick();
    check("dual_r0", 32'(out_op1_data), 32'hF000);
    check("dual_r2", 32'(out_op2_data), 32'h000F);

    // Same-edge write and read of reg 12
    drive(2'b01, 4'd12, 16'h0110, 16'h0, 4'd12, 4'd12, 1'b0, 4'd0, 1'b0); tick();
    drive(2'b00, 4'd0, 16'h0, 16'h0, 4'd12, 4'd4, 1'b0, 4'd0, 1'b0); tick();

    // Scoreboard behaviour
    drive(2'b00, 4'd0, 16'h0, 16'h0, 4'd3, 4'd1, 1'b1, 4'd3, 1'b1); tick();
    drive(2'b00, 4'd0, 16'h0, 16'h0, 4'd3, 4'd1, 1'b0, 4'd0, 1'b0); tick();
    check("sb_stall", 32'(out_stall), 32'h1);
    check("sb_cnt2", 32'(out_pending_cnt), 32'd2);
    drive(2'b01, 4'd3, 16'h3333, 16'h0, 4'd3, 4'd1, 1'b0, 4'd0, 1'b0); tick();
    check("sb_cnt1", 32'(out_pending_cnt), 32'd1);
    check("sb_op1_busy", 32'(out_op1_busy), 32'h0);
    drive(2'b01, 4'd5, 16'h5555, 16'h0, 4'd5, 4'd0, 1'b1, 4'd5, 1'b0); tick();
    check("sb_bit5", 32'(out_op1_busy), 32'h1);
    check("sb_cnt2b", 32'(out_pending_cnt), 32'd2);

    // Saturation: every register pending, re-issue holds at 16
    for (int i = 0; i < DEPTH; i++) begin
      drive(2'b00, 4'd0, 16'h0, 16'h0, 4'(i), 4'd15, 1'b1, 4'(i), 1'b0); tick();
    end
    check("sat_cnt16", 32'(out_pending_cnt), 32'd16);
    drive(2'b00, 4'd0, 16'h0, 16'h0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b1); tick();
    check("sat_reissue", 32'(out_pending_cnt), 32'd16);

    // Asynchronous reset mid-cycle, with writes and issues requested during reset
    drive(2'b01, 4'd6, 16'hBEEF, 16'h1234, 4'd4, 4'd2, 1'b0, 4'd0, 1'b0); tick();
    #2;
    in_rst = 1'b1;
    #1;
    check_all_zero("reset_async");
    drive(2'b11, 4'd6, 16'hA5A5, 16'h5A5A, 4'd6, 4'd0, 1'b1, 4'd6, 1'b1);
    @(posedge CLOCK);
    #1;
    check_all_zero("reset_hold");
    drive(2'b00, 4'd0, 16'h0, 16'h0, 4'd6, 4'd0, 1'b0, 4'd0, 1'b0);
    #2;
    in_rst = 1'b0;
    model_reset();
    tick();
    check("reset_r6", 32'(out_op1_data), 32'h0000);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      wr = 2'($urandom_range(0, 3));
      drive(wr, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 5) == 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed no end of stimulus, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
